pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline; drives the write-enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB state registers.
- Detects load-use hazards, control-transfer flushes, multi-cycle data-memory waits and HI/LO reads while the multiply/divide unit (MDU) is busy.
- Owns a small FSM and an MDU busy counter.
- Sits beside the decode stage; it reads stage register fields and produces per-stage enables.

Parameters:
- MDU_LAT, 32, cycles from MDU start (in EX) until HI/LO are valid; legal range 1..63.
- CNT_W, 6, width of the MDU busy counter; must satisfy 2^CNT_W > MDU_LAT.

Ports:
- clk  in  1  clock
- reset  in  1  reset (already decided): asynchronous, active-high
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_jump  in  1  ID holds j/jal/jr/jalr
- id_hilo_rd  in  1  ID holds mfhi/mflo
- ex_mem_read  in  1  EX holds a load
- ex_reg_dest  in  5  destination register of EX
- ex_branch_taken  in  1  branch resolved taken in EX
- ex_mdu_start  in  1  EX holds mult/multu/div/divu
- mem_req  in  1  MEM stage accesses data memory
- mem_ready  in  1  data memory completes this cycle
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_we  out  1  ID/EX write enable
- idex_flush  out  1  load bubble (all controls 0) into ID/EX
- exmem_we  out  1  EX/MEM write enable
- memwb_bubble  out  1  force WB RegWrite=0 into MEM/WB
- mdu_busy  out  1  MDU counter nonzero

Behaviour:
- State: RUN, MEM_WAIT, MDU_WAIT. Counter mdu_cnt[CNT_W-1:0].
- While reset is high: state=RUN, mdu_cnt=0, pc_we=ifid_we=idex_we=exmem_we=0, ifid_flush=idex_flush=memwb_bubble=1.
- Outputs are combinational from state, mdu_cnt and inputs. All decisions take effect on the same clock edge.
- Condition terms:
  - memstall = mem_req & ~mem_ready
  - loaduse = ex_mem_read & ex_reg_dest≠0 & ((id_uses_rs & id_rs==ex_reg_dest) | (id_uses_rt & id_rt==ex_reg_dest))
  - mdustall = id_hilo_rd & mdu_cnt≠0
- Priority, highest first:
  1. memstall: freeze all stages. pc_we=ifid_we=idex_we=exmem_we=0, memwb_bubble=1, no flushes. Entered from any state, including when a branch is taken.
  2. ex_branch_taken: all enables 1, ifid_flush=1, idex_flush=1. Overrides loaduse and mdustall, because the ID instruction is on the wrong path.
  3. loaduse or mdustall: pc_we=ifid_we=0, idex_flush=1; EX/MEM and MEM/WB advance.
  4. id_jump: all enables 1, ifid_flush=1.
  5. Otherwise: all enables 1, no flush.
- FSM transitions:
  - RUN→MEM_WAIT on memstall.
  - MEM_WAIT→RUN on mem_ready; the release cycle behaves as RUN.
  - RUN→MDU_WAIT on mdustall.
  - MDU_WAIT→RUN when mdu_cnt reaches 1.
  - MEM_WAIT has priority over MDU_WAIT; return goes to MDU_WAIT if mdustall still holds.
- Counter:
  - On ex_mdu_start & exmem_we, load MDU_LAT.
  - Otherwise decrement when nonzero; decrement continues during memstall because the MDU is autonomous.
  - A new start while busy reloads MDU_LAT.
- Load-use stalls last exactly one cycle: after the stall, the load leaves EX.
- Register 0 never causes a hazard.
- Reset mid-stall returns to RUN with mdu_cnt=0.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles increments every cycle pc_we=0 outside reset.
  - flush_events increments every cycle ifid_flush=1 outside reset.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding (RUN=2'd0, MEM_WAIT=2'd1, MDU_WAIT=2'd2)
  - REG_ZERO=5'd0
  - default MDU_LAT
- One sub-module, mdu_busy_counter: load/decrement counter that outputs mdu_busy and the last-cycle flag.

Test Plan:
- ex_mem_read=1, ex_reg_dest=8, id_uses_rs=1, id_rs=8 → one cycle of pc_we=0, ifid_we=0, idex_flush=1, then normal flow.
- Same as above but ex_reg_dest=0 → no stall.
- ex_branch_taken=1 together with a load-use condition → ifid_flush=idex_flush=1, pc_we=1, no stall.
- mem_req=1 with mem_ready low for 3 cycles, branch taken during the wait → 3 cycles all enables 0 and memwb_bubble=1; flush only on the release cycle.
- ex_mdu_start with MDU_LAT=4, id_hilo_rd asserted the next cycle → stall for the remaining counted cycles; pc_we returns to 1 when mdu_cnt reaches 1 → 0.
- Reset asserted asynchronously in MDU_WAIT → immediate reset output values, state RUN and mdu_cnt=0 after deassertion; with HAZARD_PERF_CNT_EN both counters read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encoding,
// the hard-wired zero register and the default MDU latency.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         MDU_LAT_DEF = 32;

  function automatic logic src_hit(input logic uses, input logic [4:0] src,
                                   input logic [4:0] dest);
    return uses && (src == dest);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: stage fields in, per-stage enables/flushes out.
// With HAZARD_PERF_CNT_EN defined it also carries the stall/flush counters.
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_jump;
  logic       id_hilo_rd;
  logic       ex_mem_read;
  logic [4:0] ex_reg_dest;
  logic       ex_branch_taken;
  logic       ex_mdu_start;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_we;
  logic       ifid_we;
  logic       ifid_flush;
  logic       idex_we;
  logic       idex_flush;
  logic       exmem_we;
  logic       memwb_bubble;
  logic       mdu_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_hilo_rd,
           ex_mem_read, ex_reg_dest, ex_branch_taken, ex_mdu_start,
           mem_req, mem_ready,
`ifdef HAZARD_PERF_CNT_EN
    input  stall_cycles, flush_events,
`endif
    input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
           memwb_bubble, mdu_busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_hilo_rd,
           ex_mem_read, ex_reg_dest, ex_branch_taken, ex_mdu_start,
           mem_req, mem_ready,
`ifdef HAZARD_PERF_CNT_EN
    output stall_cycles, flush_events,
`endif
    output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
           memwb_bubble, mdu_busy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_mdu_busy_counter.sv
// MDU busy down-counter: loads the latency on a start, then counts to zero
// on its own, independent of pipeline stalls.
module mdu_busy_counter #(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic mdu_busy,
  output logic mdu_last
);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MDU_LAT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (load)         cnt <= LAT;
    else if (cnt != '0)    cnt <= cnt - ONE;
  end

  assign mdu_busy = (cnt != '0);
  assign mdu_last = (cnt == ONE);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional build macro: HAZARD_PERF_CNT_EN (stall/flush event counters).
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = 6
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);
  hz_state_t state, state_nxt;
  logic memstall, loaduse, mdustall, mdu_busy, mdu_last, mdu_load;
  logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_bubble;

  assign memstall = hz.mem_req & ~hz.mem_ready;
  assign loaduse  = hz.ex_mem_read && (hz.ex_reg_dest != REG_ZERO) &&
                    (src_hit(hz.id_uses_rs, hz.id_rs, hz.ex_reg_dest) ||
                     src_hit(hz.id_uses_rt, hz.id_rt, hz.ex_reg_dest));
  assign mdustall = hz.id_hilo_rd & mdu_busy;
  // A start frozen in EX by a memory wait must not launch the MDU twice.
  assign mdu_load = hz.ex_mdu_start & exmem_we;

  mdu_busy_counter #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) u_mdu_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (mdu_load),
    .mdu_busy (mdu_busy),
    .mdu_last (mdu_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:      if (memstall)                     state_nxt = MEM_WAIT;
                else if (mdustall && !mdu_last)   state_nxt = MDU_WAIT;
      MEM_WAIT: if (!memstall)
                  state_nxt = (mdustall && !mdu_last) ? MDU_WAIT : RUN;
      MDU_WAIT: if (memstall)                     state_nxt = MEM_WAIT;
                else if (!mdustall || mdu_last)   state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    exmem_we     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (reset) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (memstall) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (hz.ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (loaduse || mdustall) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end else if (hz.id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  assign hz.pc_we        = pc_we;
  assign hz.ifid_we      = ifid_we;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_we      = idex_we;
  assign hz.idex_flush   = idex_flush;
  assign hz.exmem_we     = exmem_we;
  assign hz.memwb_bubble = memwb_bubble;
  assign hz.mdu_busy     = mdu_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_we)     stall_cycles <= stall_cycles + 32'd1;
      if (ifid_flush) flush_events <= flush_events + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_cycles;
  assign hz.flush_events = flush_events;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MDU_LAT=4).
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(.MDU_LAT(4), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0;
    hz.id_jump = 1'b0; hz.id_hilo_rd = 1'b0; hz.ex_mem_read = 1'b0;
    hz.ex_reg_dest = 5'd0; hz.ex_branch_taken = 1'b0; hz.ex_mdu_start = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_bubble}
  function automatic logic [6:0] ctl();
    return {hz.pc_we, hz.ifid_we, hz.idex_we, hz.exmem_we,
            hz.ifid_flush, hz.idex_flush, hz.memwb_bubble};
  endfunction

  localparam logic [6:0] C_RUN   = 7'b1111_000;
  localparam logic [6:0] C_RST   = 7'b0000_111;
  localparam logic [6:0] C_FRZ   = 7'b0000_001;
  localparam logic [6:0] C_STALL = 7'b0011_010;
  localparam logic [6:0] C_BR    = 7'b1111_110;
  localparam logic [6:0] C_JMP   = 7'b1111_100;

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    #2;
    n_checks++;
    if (ctl() !== C_RST) begin
      n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl(), C_RST);
    end
    n_checks++;
    if (hz.mdu_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", hz.mdu_busy);
    end
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (ctl() !== C_RUN) begin
      n_fail++; $display("FAIL idle_ctl: got %b want %b", ctl(), C_RUN);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    hz.ex_mem_read = 1'b1; hz.ex_reg_dest = 5'd8; hz.id_uses_rs = 1'b1; hz.id_rs = 5'd8;
    #1;
    n_checks++;
    if (ctl() !== C_STALL) begin
      n_fail++; $display("FAIL loaduse_rs: got %b want %b", ctl(), C_STALL);
    end
    tick();
    hz.ex_mem_read = 1'b0;
    #1;
    n_checks++;
    if (ctl() !== C_RUN) begin
      n_fail++; $display("FAIL loaduse_after: got %b want %b", ctl(), C_RUN);
    end
    hz.ex_mem_read = 1'b1; hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b1;
    hz.id_rs = 5'd3; hz.id_rt = 5'd8;
    #1;
    n_checks++;
    if (ctl() !== C_STALL) begin
      n_fail++; $display("FAIL loaduse_rt: got %b want %b", ctl(), C_STALL);
    end
    hz.id_uses_rt = 1'b0; hz.id_rs = 5'd8;
    #1;
    n_checks++;
    if (ctl() !== C_RUN) begin
      n_fail++; $display("FAIL loaduse_unused_src: got %b want %b", ctl(), C_RUN);
    end
    hz.id_uses_rs = 1'b1; hz.id_rs = 5'd9;
    #1;
    n_checks++;
    if (ctl() !== C_RUN) begin
      n_fail++; $display("FAIL loaduse_other_reg: got %b want %b", ctl(), C_RUN);
    end
    tick();
  endtask

  task automatic test_reg_zero();
    clear_inputs();
    hz.ex_mem_read = 1'b1; hz.ex_reg_dest = 5'd0;
    hz.id_uses_rs = 1'b1; hz.id_rs = 5'd0; hz.id_uses_rt = 1'b1; hz.id_rt = 5'd0;
    #1;
    n_checks++;
    if (ctl() !== C_RUN) begin
      n_fail++; $display("FAIL reg_zero: got %b want %b", ctl(), C_RUN);
    end
    tick();
  endtask

  task automatic test_branch_jump();
    clear_inputs();
    hz.ex_mem_read = 1'b1; hz.ex_reg_dest = 5'd8; hz.id_uses_rs = 1'b1; hz.id_rs = 5'd8;
    hz.ex_branch_taken = 1'b1;
    #1;
    n_checks++;
    if (ctl() !== C_BR) begin
      n_fail++; $display("FAIL branch_over_loaduse: got %b want %b", ctl(), C_BR);
    end
    tick();
    clear_inputs();
    hz.id_jump = 1'b1;
    #1;
    n_checks++;
    if (ctl() !== C_JMP) begin
      n_fail++; $display("FAIL jump: got %b want %b", ctl(), C_JMP);
    end
    hz.ex_mem_read = 1'b1; hz.ex_reg_dest = 5'd4; hz.id_uses_rt = 1'b1; hz.id_rt = 5'd4;
    #1;
    n_checks++;
    if (ctl() !== C_STALL) begin
      n_fail++; $display("FAIL loaduse_over_jump: got %b want %b", ctl(), C_STALL);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0; hz.ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ctl() !== C_FRZ) begin
        n_fail++; $display("FAIL mem_wait_%0d: got %b want %b", i, ctl(), C_FRZ);
      end
      tick();
    end
    hz.mem_ready = 1'b1;
    #1;
    n_checks++;
    if (ctl() !== C_BR) begin
      n_fail++; $display("FAIL mem_release: got %b want %b", ctl(), C_BR);
    end
    tick();
    clear_inputs();
    // A start held in EX during a memory wait must not load the counter.
    hz.mem_req = 1'b1; hz.ex_mdu_start = 1'b1;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (hz.mdu_busy !== 1'b0) begin
      n_fail++; $display("FAIL mdu_start_frozen: got %b want 0", hz.mdu_busy);
    end
  endtask

  task automatic test_mdu();
    clear_inputs();
    hz.ex_mdu_start = 1'b1;
    tick();
    hz.ex_mdu_start = 1'b0; hz.id_hilo_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (ctl() !== C_STALL || hz.mdu_busy !== 1'b1) begin
        n_fail++; $display("FAIL mdu_stall_%0d: got ctl=%b busy=%b want ctl=%b busy=1",
                           i, ctl(), hz.mdu_busy, C_STALL);
      end
      tick();
    end
    #1;
    n_checks++;
    if (ctl() !== C_RUN || hz.mdu_busy !== 1'b0) begin
      n_fail++; $display("FAIL mdu_release: got ctl=%b busy=%b want ctl=%b busy=0",
                         ctl(), hz.mdu_busy, C_RUN);
    end
    // Start, two cycles later restart: busy must last four cycles after the restart.
    clear_inputs();
    hz.ex_mdu_start = 1'b1;
    tick();
    hz.ex_mdu_start = 1'b0;
    tick();
    hz.ex_mdu_start = 1'b1;
    tick();
    hz.ex_mdu_start = 1'b0;
    tick(); tick(); tick();
    #1;
    n_checks++;
    if (hz.mdu_busy !== 1'b1) begin
      n_fail++; $display("FAIL mdu_reload_busy: got %b want 1", hz.mdu_busy);
    end
    // Counter keeps running through a memory wait.
    hz.mem_req = 1'b1;
    tick();
    n_checks++;
    if (hz.mdu_busy !== 1'b0) begin
      n_fail++; $display("FAIL mdu_dec_in_memstall: got %b want 0", hz.mdu_busy);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    hz.ex_mdu_start = 1'b1;
    tick();
    hz.ex_mdu_start = 1'b0; hz.id_hilo_rd = 1'b1;
    tick();
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if (ctl() !== C_RST || hz.mdu_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_async: got ctl=%b busy=%b want ctl=%b busy=0",
                         ctl(), hz.mdu_busy, C_RST);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (hz.stall_cycles !== 32'd0 || hz.flush_events !== 32'd0) begin
      n_fail++; $display("FAIL perf_clear: got stall=%0d flush=%0d want 0 0",
                         hz.stall_cycles, hz.flush_events);
    end
`endif
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (ctl() !== C_RUN) begin
      n_fail++; $display("FAIL after_reset_hilo: got %b want %b", ctl(), C_RUN);
    end
`ifdef HAZARD_PERF_CNT_EN
    hz.ex_branch_taken = 1'b1; hz.mem_req = 1'b0;
    tick();
    hz.ex_branch_taken = 1'b0; hz.mem_req = 1'b1;
    tick(); tick();
    n_checks++;
    if (hz.stall_cycles !== 32'd2 || hz.flush_events !== 32'd1) begin
      n_fail++; $display("FAIL perf_count: got stall=%0d flush=%0d want 2 1",
                         hz.stall_cycles, hz.flush_events);
    end
`endif
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg_zero();
    test_branch_jump();
    test_mem_wait();
    test_mdu();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
